log_detector_scheduler: RTL

//  Shares one log_position_detector among NUM_CH power sources. Buffers one 32-bit power word per

---
 rtl/log_sched_pkg.sv | 47 ++++
 rtl/log_sched_out_fifo.sv | 84 ++++++++
 rtl/log_detector_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/log_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : log_sched_pkg
// Description : Shared widths, default detector latency, tag and result
//               record layouts for the log-detector scheduler.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package log_sched_pkg;

    // Default pipeline latency of the shared log_position_detector.
    localparam int DET_LATENCY = 5;

    localparam int WORD_W = 32;
    localparam int CH_W   = 3;
    localparam int POS_W  = 5;
    localparam int PREC_W = 4;

    // Result record as stored in the output FIFO (MSB first).
    typedef struct packed {
        logic [CH_W-1:0]   channel;
        logic [POS_W-1:0]  position;
        logic [PREC_W-1:0] precision;
        logic              zero;
    } sched_res_t;

    localparam int RES_W        = $bits(sched_res_t);
    localparam int RES_ZERO_LSB = 0;
    localparam int RES_PREC_LSB = RES_ZERO_LSB + 1;
    localparam int RES_POS_LSB  = RES_PREC_LSB + PREC_W;
    localparam int RES_CH_LSB   = RES_POS_LSB + POS_W;

    // Tag carried alongside the detector pipeline.
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] channel;
        logic            zero;
    } sched_tag_t;

    // Input 0 and input 1 both produce position 0 / precision 0 at the
    // detector; this flag tells them apart downstream.
    function automatic logic is_zero_word(input logic [WORD_W-1:0] w);
        return (w == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/log_sched_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : log_sched_out_fifo
// Description : First-word-fall-through result FIFO with occupancy output.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               push_i/data_i - write strobe and data
//               pop_i        - consumer accepts head (ignored when empty)
//               valid_o      - FIFO not empty
//               data_o       - head entry (zero while empty)
//               count_o      - current number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module log_sched_out_fifo
    import log_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = RES_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    count_q;

    logic do_pop;
    logic do_push;
    logic empty;
    logic full;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign valid_o = ~empty;
    assign data_o  = empty ? '0 : mem_q[rd_q];
    assign count_o = count_q;

    // Upstream credit gating must make an unaccepted push impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push_i && full && !pop_i));

endmodule
`default_nettype wire

// File: rtl/log_detector_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : log_detector_scheduler
// Description : Shares one log_position_detector among NUM_CH channels.
//               One word is buffered per channel, the detector is granted
//               round-robin (one issue per cycle), each issue is tagged with
//               its channel and the tag is re-joined with the detector result
//               after DET_LATENCY cycles. Results leave through a FWFT FIFO;
//               issue is credit-gated so the non-stallable detector can never
//               overrun that FIFO.
// Ports       : clk, rst              - clock, asynchronous active-high reset
//               req_valid_i/power_i   - per-channel word offer (ch i at 32*i)
//               req_ready_o           - per-channel buffer empty
//               det_valid_in_o/power  - issue register to the detector
//               det_position/precision/valid_out_i - detector results
//               res_valid_o/ready_i   - result handshake (FIFO head)
//               res_channel/position/precision/zero_o - result fields
//               err_sync_o            - sticky tag/detector misalignment
// Revision    : 1.0 - initial release
// ============================================================================
module log_detector_scheduler
    import log_sched_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DET_LATENCY = log_sched_pkg::DET_LATENCY,
    parameter int OUT_DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid_i,
    input  logic [WORD_W*NUM_CH-1:0] req_power_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    output logic                     det_valid_in_o,
    output logic [WORD_W-1:0]        det_power_in_o,
    input  logic [POS_W-1:0]         det_position_i,
    input  logic [PREC_W-1:0]        det_precision_i,
    input  logic                     det_valid_out_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [CH_W-1:0]          res_channel_o,
    output logic [POS_W-1:0]         res_position_o,
    output logic [PREC_W-1:0]        res_precision_o,
    output logic                     res_zero_o,
    output logic                     err_sync_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH) + 1;
    localparam int BLK_W = $clog2(DET_LATENCY + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WORD_W-1:0] buf_q [NUM_CH];
    logic [NUM_CH-1:0] full_q;
    logic [PTR_W-1:0]  rr_q;
    logic              det_valid_q;
    logic [WORD_W-1:0] det_power_q;
    logic [BLK_W-1:0]  blank_q;
    logic              err_q;

    // tag_q[0] is loaded together with the issue register; the following
    // DET_LATENCY stages track the detector, so tag_q[DET_LATENCY] lines up
    // with det_valid_out_i.
    sched_tag_t tag_q [DET_LATENCY+1];

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic             grant_valid;
    logic [PTR_W-1:0] grant_idx;
    int               scan_idx;
    int               inflight;
    logic             credit_ok;
    logic             issue;
    logic [CNT_W-1:0] fifo_count;
    sched_tag_t       tag_exit;
    sched_res_t       push_res;
    logic             fifo_valid;
    logic [RES_W-1:0] fifo_head;

    // Round-robin: first full channel strictly after the last grant.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            scan_idx = int'(rr_q) + k;
            if (scan_idx >= NUM_CH) begin
                scan_idx = scan_idx - NUM_CH;
            end
            if (!grant_valid && full_q[PTR_W'(scan_idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'(scan_idx);
            end
        end
    end

    // Every valid tag stage is a result that will land in the FIFO; the
    // FIFO plus everything in flight must stay within its depth.
    always_comb begin
        inflight = 0;
        for (int j = 0; j <= DET_LATENCY; j++) begin
            if (tag_q[j].valid) begin
                inflight = inflight + 1;
            end
        end
    end

    assign credit_ok = (int'(fifo_count) + inflight) < OUT_DEPTH;
    // While blanking, the unreset detector is still draining junk.
    assign issue     = grant_valid && credit_ok && (blank_q == '0);

    assign tag_exit  = tag_q[DET_LATENCY];

    always_comb begin
        push_res           = '0;
        push_res.channel   = tag_exit.channel;
        push_res.position  = det_position_i;
        push_res.precision = det_precision_i;
        push_res.zero      = tag_exit.zero;
    end

    // ------------------------------------------------------------------
    // Channel buffers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                buf_q[i] <= '0;
            end
            full_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                // A granted buffer is freed but not refilled in the same cycle.
                if (issue && (grant_idx == PTR_W'(i))) begin
                    full_q[i] <= 1'b0;
                end else if (req_valid_i[i] && !full_q[i]) begin
                    buf_q[i]  <= req_power_i[WORD_W*i +: WORD_W];
                    full_q[i] <= 1'b1;
                end
            end
        end
    end

    assign req_ready_o = ~full_q;

    // ------------------------------------------------------------------
    // Issue register, tag pipe, blanking, sync error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= PTR_W'(NUM_CH - 1);
            det_valid_q <= 1'b0;
            det_power_q <= '0;
            blank_q     <= BLK_W'(DET_LATENCY);
            err_q       <= 1'b0;
            for (int j = 0; j <= DET_LATENCY; j++) begin
                tag_q[j] <= '0;
            end
        end else begin
            det_valid_q <= issue;
            if (issue) begin
                rr_q        <= grant_idx;
                det_power_q <= buf_q[grant_idx];
                tag_q[0]    <= '{valid:   1'b1,
                                 channel: CH_W'(grant_idx),
                                 zero:    is_zero_word(buf_q[grant_idx])};
            end else begin
                tag_q[0] <= '0;
            end
            for (int j = 1; j <= DET_LATENCY; j++) begin
                tag_q[j] <= tag_q[j-1];
            end
            if (blank_q != '0) begin
                blank_q <= blank_q - BLK_W'(1);
            end
            if (tag_exit.valid && !det_valid_out_i) begin
                err_q <= 1'b1;
            end
        end
    end

    assign det_valid_in_o = det_valid_q;
    assign det_power_in_o = det_power_q;
    assign err_sync_o     = err_q;

    // ------------------------------------------------------------------
    // Output FIFO; entries are pushed on tag exit even if the detector
    // failed to flag valid, so the consumer still sees one result per word.
    // ------------------------------------------------------------------
    log_sched_out_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (RES_W)
    ) u_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (tag_exit.valid),
        .data_i  (push_res),
        .pop_i   (res_ready_i),
        .valid_o (fifo_valid),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign res_valid_o     = fifo_valid;
    assign res_channel_o   = fifo_head[RES_CH_LSB   +: CH_W];
    assign res_position_o  = fifo_head[RES_POS_LSB  +: POS_W];
    assign res_precision_o = fifo_head[RES_PREC_LSB +: PREC_W];
    assign res_zero_o      = fifo_head[RES_ZERO_LSB];

endmodule
`default_nettype wire
